// File: rtl/dot_seq_pkg.sv
// dot_seq_pkg: shared types and constants for the dot-product sequencer.
package dot_seq_pkg;

  localparam int DEF_MACC_LAT = 3;
  localparam int DEF_CNT_W    = 16;

  // Term count saturates here instead of wrapping (default count width).
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

  // One in-flight term as tracked alongside the accumulator pipeline.
  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [DEF_CNT_W-1:0] count;
  } tag_t;

endpackage

// File: rtl/dot_seq_tagpipe.sv
// dot_seq_tagpipe: shift register of occupancy tags mirroring the MACC latency.
// Valid bits are reset; payload (last flag and optional count) is plain data.
module dot_seq_tagpipe
  import dot_seq_pkg::*;
#(
  parameter int L  = DEF_MACC_LAT,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          clr_tail,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          tail_valid,
  output logic [DW-1:0] tail_data,
  output logic          any_valid
);

  logic [L-1:0]  vld;
  logic [DW-1:0] dat [L];

  // Valid bits: shift on advance; otherwise retire a consumed tail tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int i = 1; i < L; i++) vld[i] <= vld[i-1];
    end else if (clr_tail) begin
      vld[L-1] <= 1'b0;
    end
  end

  // Payload follows the valid bits without reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      dat[0] <= in_data;
      for (int i = 1; i < L; i++) dat[i] <= dat[i-1];
    end
  end

  assign tail_valid = vld[L-1];
  assign tail_data  = dat[L-1];
  assign any_valid  = |vld;

endmodule

// File: rtl/dot_seq.sv
// dot_seq: drives a streaming MACC from a last-delimited operand-pair stream
// and returns one accumulated sum per vector on a valid/ready port.
// Optional feature macro: DOT_SEQ_CNT_EN (term count carried in tags and
// reported on out_count; otherwise out_count is tied to 0).
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int SIZEIN   = 16,
  parameter int SIZEOUT  = 40,
  parameter int MACC_LAT = DEF_MACC_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SIZEIN-1:0]  in_a,
  input  logic signed [SIZEIN-1:0]  in_b,
  input  logic                      in_last,
  output logic                      macc_ce,
  output logic                      macc_sload,
  output logic signed [SIZEIN-1:0]  macc_a,
  output logic signed [SIZEIN-1:0]  macc_b,
  input  logic signed [SIZEOUT-1:0] macc_accum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [SIZEOUT-1:0] out_data,
  output logic [CNT_W-1:0]          out_count
);

`ifdef DOT_SEQ_CNT_EN
  localparam int PW = 1 + CNT_W;
`else
  localparam int PW = 1;
`endif

  logic          first;
  logic          accept, flush, stall, capture, clr_tail;
  logic          tail_v, any_v, tail_last;
  logic [PW-1:0] tag_in, tail_d;

  assign tail_last = tail_d[PW-1];

  // Accept / flush decision; macc_* are combinational from it.
  always_comb begin
    stall      = tail_v && tail_last && out_valid && !out_ready;
    in_ready   = !rst && !stall;
    accept     = in_valid && in_ready;
    flush      = !rst && !accept && !stall && any_v;
    macc_ce    = accept || flush;
    macc_sload = accept && first;
    macc_a     = accept ? in_a : '0;
    macc_b     = accept ? in_b : '0;
    capture    = !rst && tail_v && tail_last && !stall;
    clr_tail   = capture && !macc_ce;
  end

  // Next accepted pair opens a new vector after reset or after a last pair.
  always_ff @(posedge clk) begin
    if (rst)         first <= 1'b1;
    else if (accept) first <= in_last;
  end

`ifdef DOT_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_run, cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign cnt_next = first ? CNT_W'(1) : sat_inc(cnt_run);
  assign tag_in   = {accept && in_last, cnt_next};

  // Running term count of the open vector.
  always_ff @(posedge clk) begin
    if (accept) cnt_run <= cnt_next;
  end

  // Count of the captured vector, taken from its last tag.
  always_ff @(posedge clk) begin
    if (rst)          out_count <= '0;
    else if (capture) out_count <= tail_d[CNT_W-1:0];
  end
`else
  assign tag_in    = accept && in_last;
  assign out_count = '0;
`endif

  dot_seq_tagpipe #(.L(MACC_LAT), .DW(PW)) u_tagpipe (
    .clk        (clk),
    .rst        (rst),
    .adv        (macc_ce),
    .clr_tail   (clr_tail),
    .in_valid   (accept),
    .in_data    (tag_in),
    .tail_valid (tail_v),
    .tail_data  (tail_d),
    .any_valid  (any_v)
  );

  // Result register: a new capture wins over a same-edge handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= macc_accum;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_seq.sv
// tb_dot_seq: randomized + directed scoreboard bench for dot_seq with a
// behavioural MACC stand-in and a vector-level reference model.
module tb_dot_seq;
  import dot_seq_pkg::*;

  localparam int SIZEIN = 16, SIZEOUT = 40, LAT = 3, CW = 16;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 1;
  logic signed [SIZEIN-1:0] in_a = '0, in_b = '0;
  logic in_ready, macc_ce, macc_sload, out_valid;
  logic signed [SIZEIN-1:0] macc_a, macc_b;
  logic signed [SIZEOUT-1:0] macc_accum, out_data;
  logic [CW-1:0] out_count;

  dot_seq #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .MACC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .macc_ce(macc_ce), .macc_sload(macc_sload), .macc_a(macc_a), .macc_b(macc_b),
    .macc_accum(macc_accum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MACC: a term enters the sum after LAT ce-enabled edges.
  longint mp [LAT-1];
  bit     ms [LAT-1];
  longint acc = 0;
  initial for (int i = 0; i < LAT-1; i++) begin mp[i] = 0; ms[i] = 0; end
  always @(posedge clk) if (macc_ce) begin
    mp[0] <= longint'(macc_a) * longint'(macc_b);
    ms[0] <= macc_sload;
    for (int i = 1; i < LAT-1; i++) begin mp[i] <= mp[i-1]; ms[i] <= ms[i-1]; end
    acc <= ms[LAT-2] ? mp[LAT-2] : acc + mp[LAT-2];
  end
  assign macc_accum = SIZEOUT'(acc);

  // Scoreboard
  typedef struct { longint sum; int cnt; int acc_cyc; bit chk_lat; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit m_first = 1;
  longint m_sum = 0;
  int m_cnt = 0;
  int n_drop = 0, n_flush = 0;
  bit rand_rdy = 0;

  function automatic void check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compares every presented result; pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got data %0d, expected no result", out_data);
      end else begin
        check("out_data", out_data, q[0].sum);
`ifdef DOT_SEQ_CNT_EN
        check("out_count", out_count, q[0].cnt);
`else
        check("out_count", out_count, 0);
`endif
        if (out_ready) begin
          if (q[0].chk_lat) check("latency", cyc - q[0].acc_cyc, LAT + 1);
          void'(q.pop_front());
        end
      end
    end
    if (macc_ce && !in_valid) n_flush++;
  end

  // Random back-pressure on the result port.
  always @(posedge clk) if (rand_rdy) begin
    #1;
    out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int a, input int b, input bit last, input bit chk_lat = 0);
    int guard = 0;
    bit done = 0;
    in_valid = 1; in_a = SIZEIN'(a); in_b = SIZEIN'(b); in_last = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        check("macc_ce", macc_ce, 1);
        check("macc_sload", macc_sload, m_first);
        check("macc_ab", longint'(macc_a) * longint'(macc_b), longint'(a) * b);
        if (m_first) begin
          m_sum = longint'(a) * b; m_cnt = 1;
        end else begin
          m_sum += longint'(a) * b;
          if (m_cnt < int'(CNT_SAT)) m_cnt++;
        end
        m_first = last;
        if (last) q.push_back('{m_sum, m_cnt, cyc, chk_lat});
        done = 1;
      end else begin
        n_drop++;
        if (++guard > 300) begin
          n_cmp++; n_bad++;
          $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", guard);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((q.size() != 0 || out_valid) && k < bound) begin
      @(posedge clk); k++;
    end
    #1;
    if (q.size() != 0 || out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_macc_ce", macc_ce, 0);
    check("rst_macc_sload", macc_sload, 0);
    check("rst_macc_a", macc_a, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    @(posedge clk); #1;
    rst = 0;
    idle(2);

    // Three-term vector with latency check
    send(2, 3, 0); send(4, 5, 0); send(-1, 7, 1, 1);
    drain(50);

    // Single-pair vector
    send(-5, 6, 1);
    drain(50);

    // Back-to-back vectors, no in_ready drop
    n_drop = 0;
    send(1, 1, 0); send(1, 1, 1); send(3, 3, 1);
    check("no_ready_drop", n_drop, 0);
    drain(50);

    // Back-pressure with two vectors queued
    out_ready = 0;
    send(1, 2, 1); send(3, 4, 1);
    idle(8);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1;
    drain(50);

    // Starvation mid-vector
    n_flush = 0;
    send(2, 2, 0);
    idle(5);
    check("flush_seen", n_flush > 0, 1);
    send(3, 3, 1);
    drain(50);

    // Reset mid-vector
    send(9, 9, 0);
    rst = 1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    m_first = 1; q.delete();
    send(1, 2, 1);
    drain(50);

    // Randomized traffic with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 3) == 0);
    end
    send(int'($urandom_range(0, 200)) - 100, 7, 1);
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1;
    drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
